// File: rtl/gray_bin_convert_pipe.sv
// rtl/gray_bin_convert_pipe.sv - pipelined bidirectional Gray/binary converter with valid/ready streams
module gray_bin_convert_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             mode_out
);

    // Bits of the Gray->binary prefix chain resolved per stage.
    localparam int S = WIDTH / STAGES;

    logic [STAGES:1] stage_valid;
    logic [STAGES:1] stage_mode;
    logic [WIDTH-1:0] stage_data [1:STAGES];
    logic [STAGES:1] load;
    logic [STAGES:1] advance;

    // Ready chain from the output back to stage 1: a stage loads when empty or draining.
    always_comb begin
        load    = '0;
        advance = '0;
        advance[STAGES] = stage_valid[STAGES] & out_ready;
        load[STAGES]    = ~stage_valid[STAGES] | advance[STAGES];
        for (int k = STAGES - 1; k >= 1; k--) begin
            advance[k] = stage_valid[k] & load[k+1];
            load[k]    = ~stage_valid[k] | advance[k];
        end
    end

    assign in_ready = load[1];

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        // Slice of the binary result this stage finishes (MSB-first).
        localparam int HI = WIDTH - 1 - (k - 1) * S;
        localparam int LO = WIDTH - k * S;

        logic [WIDTH-1:0] src;
        logic             src_valid;
        logic             src_mode;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] data_q;
        logic             valid_q;
        logic             mode_q;

        if (k == 1) begin : g_src_in
            assign src       = data_in;
            assign src_valid = in_valid;
            assign src_mode  = mode;
        end else begin : g_src_prev
            assign src       = stage_data[k-1];
            assign src_valid = stage_valid[k-1];
            assign src_mode  = stage_mode[k-1];
        end

        // Binary->Gray finishes in stage 1; Gray->binary resolves this stage's slice
        // from the already-binary bit just above it, leaving lower Gray bits untouched.
        always_comb begin
            nxt = src;
            if (src_mode) begin
                if (k == 1) begin
                    nxt = src ^ (src >> 1);
                end
            end else begin
                for (int i = WIDTH - 2; i >= 0; i--) begin
                    if (i <= HI && i >= LO) begin
                        nxt[i] = nxt[i+1] ^ src[i];
                    end
                end
            end
        end

        // Stage register: flush wins over transfers; payload only moves with a valid word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                mode_q  <= 1'b0;
                data_q  <= '0;
            end else if (clr) begin
                valid_q <= 1'b0;
            end else if (load[k]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    data_q <= nxt;
                    mode_q <= src_mode;
                end
            end
        end

        assign stage_valid[k] = valid_q;
        assign stage_mode[k]  = mode_q;
        assign stage_data[k]  = data_q;
    end

    assign out_valid = stage_valid[STAGES];
    assign data_out  = stage_data[STAGES];
    assign mode_out  = stage_mode[STAGES];

endmodule
